// File: rtl/id_stage.sv
// id_stage: MIPS-I subset decode stage with GPR forwarding, load-use detection, branch resolution and ID/EX register
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_pc, if_insn, if_en         fetched instruction and its PC from fetch
//   stall, flush                  hold / kill the ID/EX register
//   gpr_rd_addr0/1, gpr_rd_data0/1  rs/rt read ports of the GPR file (combinational)
//   ex_fwd_*, ex_is_load          EX-stage result and load flag for forwarding / hazard detection
//   mem_fwd_*                     MEM-stage result for forwarding
//   br_taken, br_addr, ld_hazard  combinational redirect and stall request back to fetch
//   id_*                          ID/EX pipeline register outputs
module id_stage #(
    parameter int DATA_W = 32,
    parameter int GPR_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_insn,
    input  logic              if_en,
    input  logic              stall,
    input  logic              flush,
    output logic [GPR_AW-1:0] gpr_rd_addr0,
    output logic [GPR_AW-1:0] gpr_rd_addr1,
    input  logic [DATA_W-1:0] gpr_rd_data0,
    input  logic [DATA_W-1:0] gpr_rd_data1,
    input  logic              ex_fwd_we,
    input  logic [GPR_AW-1:0] ex_fwd_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              ex_is_load,
    input  logic              mem_fwd_we,
    input  logic [GPR_AW-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_addr,
    output logic              ld_hazard,
    output logic [DATA_W-1:0] id_pc,
    output logic              id_en,
    output logic [3:0]        id_alu_op,
    output logic [DATA_W-1:0] id_alu_in0,
    output logic [DATA_W-1:0] id_alu_in1,
    output logic [GPR_AW-1:0] id_dst_addr,
    output logic              id_gpr_we,
    output logic [1:0]        id_mem_op,
    output logic [DATA_W-1:0] id_mem_wr_data,
    output logic              id_illegal
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4,
                           ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8, ALU_PASS_B = 4'd9;
    localparam logic [1:0] MEM_NONE = 2'd0, MEM_LW = 2'd1, MEM_SW = 2'd2;

    logic [5:0] opc, fn;
    logic [GPR_AW-1:0] rs, rt, rd, dst;
    logic [DATA_W-1:0] a, b, simm, zimm, limm, shamt, pc4, pc8, jaddr, in0, in1;
    logic is_r, is_addu, is_subu, is_and, is_or, is_xor, is_slt, is_sll, is_srl, is_jr;
    logic is_addiu, is_andi, is_ori, is_lui, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
    logic legal, uses_rs, uses_rt, br_cond, we;
    logic [3:0] alu_op;
    logic [1:0] mem_op;

    assign opc   = if_insn[31:26];
    assign fn    = if_insn[5:0];
    assign rs    = GPR_AW'(if_insn[25:21]);
    assign rt    = GPR_AW'(if_insn[20:16]);
    assign rd    = GPR_AW'(if_insn[15:11]);
    assign gpr_rd_addr0 = rs;
    assign gpr_rd_addr1 = rt;

    assign is_r     = opc == 6'h00;
    assign is_addu  = is_r && fn == 6'h21;
    assign is_subu  = is_r && fn == 6'h23;
    assign is_and   = is_r && fn == 6'h24;
    assign is_or    = is_r && fn == 6'h25;
    assign is_xor   = is_r && fn == 6'h26;
    assign is_slt   = is_r && fn == 6'h2a;
    assign is_sll   = is_r && fn == 6'h00;
    assign is_srl   = is_r && fn == 6'h02;
    assign is_jr    = is_r && fn == 6'h08;
    assign is_j     = opc == 6'h02;
    assign is_jal   = opc == 6'h03;
    assign is_beq   = opc == 6'h04;
    assign is_bne   = opc == 6'h05;
    assign is_addiu = opc == 6'h09;
    assign is_andi  = opc == 6'h0c;
    assign is_ori   = opc == 6'h0d;
    assign is_lui   = opc == 6'h0f;
    assign is_lw    = opc == 6'h23;
    assign is_sw    = opc == 6'h2b;
    assign legal = is_addu | is_subu | is_and | is_or | is_xor | is_slt | is_sll | is_srl | is_jr |
                   is_addiu | is_andi | is_ori | is_lui | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

    // Forwarding priority: r0 is hard zero, then the younger EX result, then MEM, then the register file
    assign a = rs == '0 ? '0 : (ex_fwd_we && ex_fwd_addr == rs) ? ex_fwd_data :
               (mem_fwd_we && mem_fwd_addr == rs) ? mem_fwd_data : gpr_rd_data0;
    assign b = rt == '0 ? '0 : (ex_fwd_we && ex_fwd_addr == rt) ? ex_fwd_data :
               (mem_fwd_we && mem_fwd_addr == rt) ? mem_fwd_data : gpr_rd_data1;

    assign simm  = {{(DATA_W-16){if_insn[15]}}, if_insn[15:0]};
    assign zimm  = {{(DATA_W-16){1'b0}}, if_insn[15:0]};
    assign limm  = {if_insn[15:0], {(DATA_W-16){1'b0}}};
    assign shamt = {{(DATA_W-5){1'b0}}, if_insn[10:6]};
    assign pc4   = if_pc + DATA_W'(4);
    assign pc8   = if_pc + DATA_W'(8);
    assign jaddr = {pc4[DATA_W-1:28], if_insn[25:0], 2'b00};

    assign uses_rs = !(is_j || is_jal || is_lui || is_sll || is_srl);
    assign uses_rt = is_r || is_beq || is_bne || is_sw;
    assign ld_hazard = if_en && ex_is_load && ex_fwd_addr != '0 &&
                       ((uses_rs && ex_fwd_addr == rs) || (uses_rt && ex_fwd_addr == rt));

    assign br_cond  = is_j || is_jal || is_jr || (is_beq && a == b) || (is_bne && a != b);
    assign br_taken = if_en && !ld_hazard && !stall && br_cond;
    assign br_addr  = !br_taken ? '0 : is_jr ? a : (is_j || is_jal) ? jaddr : pc4 + (simm << 2);

    assign alu_op = is_subu ? ALU_SUB : (is_and || is_andi) ? ALU_AND : (is_or || is_ori) ? ALU_OR :
                    is_xor ? ALU_XOR : is_slt ? ALU_SLT : is_sll ? ALU_SLL : is_srl ? ALU_SRL :
                    is_lui ? ALU_LUI : is_jal ? ALU_PASS_B : ALU_ADD;
    // Shifts operate on rt by shamt; JAL carries the link address on both operands
    assign in0 = (is_sll || is_srl) ? b : is_jal ? pc8 : is_lui ? '0 : a;
    assign in1 = (is_sll || is_srl) ? shamt : is_jal ? pc8 : is_lui ? limm :
                 (is_andi || is_ori) ? zimm : (is_addiu || is_lw || is_sw) ? simm : b;
    assign dst = is_jal ? GPR_AW'(31) : is_r ? rd : rt;
    assign we  = legal && !(is_sw || is_beq || is_bne || is_j || is_jr) && dst != '0;
    assign mem_op = is_lw ? MEM_LW : is_sw ? MEM_SW : MEM_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc          <= '0;
            id_en          <= 1'b0;
            id_alu_op      <= ALU_ADD;
            id_alu_in0     <= '0;
            id_alu_in1     <= '0;
            id_dst_addr    <= '0;
            id_gpr_we      <= 1'b0;
            id_mem_op      <= MEM_NONE;
            id_mem_wr_data <= '0;
            id_illegal     <= 1'b0;
        end else if (flush || (!stall && (ld_hazard || !if_en))) begin
            id_en      <= 1'b0;
            id_gpr_we  <= 1'b0;
            id_mem_op  <= MEM_NONE;
            id_illegal <= 1'b0;
        end else if (!stall) begin
            id_pc          <= if_pc;
            id_en          <= 1'b1;
            id_alu_op      <= alu_op;
            id_alu_in0     <= in0;
            id_alu_in1     <= in1;
            id_dst_addr    <= dst;
            id_gpr_we      <= we;
            id_mem_op      <= mem_op;
            id_mem_wr_data <= b;
            id_illegal     <= !legal;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a mnemonic-level reference model
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] if_pc, if_insn;
    logic if_en, stall, flush;
    logic [4:0] gpr_rd_addr0, gpr_rd_addr1;
    logic [31:0] gpr_rd_data0, gpr_rd_data1;
    logic ex_fwd_we, ex_is_load, mem_fwd_we;
    logic [4:0] ex_fwd_addr, mem_fwd_addr;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic br_taken, ld_hazard, id_en, id_gpr_we, id_illegal;
    logic [31:0] br_addr, id_pc, id_alu_in0, id_alu_in1, id_mem_wr_data;
    logic [3:0] id_alu_op;
    logic [4:0] id_dst_addr;
    logic [1:0] id_mem_op;
    logic [31:0] rf [32];
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic en; logic [3:0] op; logic [31:0] in0, in1; logic [4:0] dst;
        logic we; logic [1:0] mem; logic [31:0] wd; logic ill; logic [31:0] pc; logic dc;
    } st_t;
    st_t exp_q;

    always #5 clk = ~clk;

    assign gpr_rd_data0 = rf[if_insn[25:21]];
    assign gpr_rd_data1 = rf[if_insn[20:16]];

    id_stage #(.DATA_W(32), .GPR_AW(5)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en),
        .stall(stall), .flush(flush),
        .gpr_rd_addr0(gpr_rd_addr0), .gpr_rd_addr1(gpr_rd_addr1),
        .gpr_rd_data0(gpr_rd_data0), .gpr_rd_data1(gpr_rd_data1),
        .ex_fwd_we(ex_fwd_we), .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .br_taken(br_taken), .br_addr(br_addr), .ld_hazard(ld_hazard),
        .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op), .id_alu_in0(id_alu_in0), .id_alu_in1(id_alu_in1),
        .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .id_mem_op(id_mem_op),
        .id_mem_wr_data(id_mem_wr_data), .id_illegal(id_illegal)
    );

    function automatic logic [31:0] r_i(input logic [5:0] fn, input logic [4:0] s, t, d, sh);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_i(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] val(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (ex_fwd_we && ex_fwd_addr == r) return ex_fwd_data;
        if (mem_fwd_we && mem_fwd_addr == r) return mem_fwd_data;
        return rf[r];
    endfunction

    // Reference decode from mnemonic semantics; dc marks ALU operands that carry no meaning
    function automatic void model(input logic [31:0] pc, insn, output st_t s, output logic hz, bt,
                                  output logic [31:0] ba);
        string mn;
        logic [4:0] rs, rt, rd;
        logic [31:0] a, b, se, ze;
        logic urs, urt, cond;
        rs = insn[25:21]; rt = insn[20:16]; rd = insn[15:11];
        a = val(rs); b = val(rt);
        se = {{16{insn[15]}}, insn[15:0]}; ze = {16'h0, insn[15:0]};
        case (insn[31:26])
            6'h00: case (insn[5:0])
                6'h21: mn = "ADDU"; 6'h23: mn = "SUBU"; 6'h24: mn = "AND"; 6'h25: mn = "OR";
                6'h26: mn = "XOR"; 6'h2a: mn = "SLT"; 6'h00: mn = "SLL"; 6'h02: mn = "SRL";
                6'h08: mn = "JR"; default: mn = "ILL";
            endcase
            6'h09: mn = "ADDIU"; 6'h0c: mn = "ANDI"; 6'h0d: mn = "ORI"; 6'h0f: mn = "LUI";
            6'h23: mn = "LW"; 6'h2b: mn = "SW"; 6'h04: mn = "BEQ"; 6'h05: mn = "BNE";
            6'h02: mn = "J"; 6'h03: mn = "JAL";
            default: mn = "ILL";
        endcase
        s.en = 1'b1; s.op = 4'd0; s.in0 = a; s.in1 = b; s.dst = rt; s.we = 1'b0;
        s.mem = 2'd0; s.wd = b; s.ill = 1'b0; s.pc = pc; s.dc = 1'b0;
        case (mn)
            "ADDU":  begin s.dst = rd; s.we = 1; end
            "SUBU":  begin s.op = 1; s.dst = rd; s.we = 1; end
            "AND":   begin s.op = 2; s.dst = rd; s.we = 1; end
            "OR":    begin s.op = 3; s.dst = rd; s.we = 1; end
            "XOR":   begin s.op = 4; s.dst = rd; s.we = 1; end
            "SLT":   begin s.op = 5; s.dst = rd; s.we = 1; end
            "SLL":   begin s.op = 6; s.in0 = b; s.in1 = {27'h0, insn[10:6]}; s.dst = rd; s.we = 1; end
            "SRL":   begin s.op = 7; s.in0 = b; s.in1 = {27'h0, insn[10:6]}; s.dst = rd; s.we = 1; end
            "ADDIU": begin s.in1 = se; s.we = 1; end
            "ANDI":  begin s.op = 2; s.in1 = ze; s.we = 1; end
            "ORI":   begin s.op = 3; s.in1 = ze; s.we = 1; end
            "LUI":   begin s.op = 8; s.in0 = 0; s.in1 = {insn[15:0], 16'h0}; s.we = 1; end
            "LW":    begin s.in1 = se; s.we = 1; s.mem = 1; end
            "SW":    begin s.in1 = se; s.mem = 2; end
            "JAL":   begin s.op = 9; s.in0 = pc + 8; s.in1 = pc + 8; s.dst = 31; s.we = 1; end
            "ILL":   begin s.ill = 1; s.dc = 1; end
            default: s.dc = 1;
        endcase
        s.we = s.we && s.dst != 0;
        urs = !(mn == "J" || mn == "JAL" || mn == "LUI" || mn == "SLL" || mn == "SRL");
        urt = insn[31:26] == 0 || mn == "BEQ" || mn == "BNE" || mn == "SW";
        hz = if_en && ex_is_load && ex_fwd_addr != 0 && ((urs && ex_fwd_addr == rs) || (urt && ex_fwd_addr == rt));
        cond = mn == "J" || mn == "JAL" || mn == "JR" || (mn == "BEQ" && a == b) || (mn == "BNE" && a != b);
        bt = if_en && !hz && !stall && cond;
        ba = !bt ? 32'h0 : mn == "JR" ? a : (mn == "J" || mn == "JAL") ? {pc[31:28] + 4'(pc[27:0] > 28'hffffffb), insn[25:0], 2'b00}
             : pc + 4 + (se << 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        if_pc = 0; if_insn = 0; if_en = 0; stall = 0; flush = 0;
        ex_fwd_we = 0; ex_fwd_addr = 0; ex_fwd_data = 0; ex_is_load = 0;
        mem_fwd_we = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1;
        if_insn = {6'h03, 26'h40};
        tick(); tick();
        vectors++;
        if ({id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_mem_op, id_mem_wr_data, id_illegal, id_pc} !== '0) begin
            miscompares++;
            $display("FAIL reset_state id_* got %h required 0", {id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_mem_op, id_mem_wr_data, id_illegal, id_pc});
        end
        vectors++;
        if ({br_taken, ld_hazard} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_comb br_taken/ld_hazard got %b required 00", {br_taken, ld_hazard});
        end
        rst = 0;
    endtask

    task automatic test_addu();
        clr_in();
        rf[0] = 32'hdead_beef; rf[1] = 5; rf[2] = 7;
        if_insn = r_i(6'h21, 1, 2, 3, 0); if_pc = 32'h40; if_en = 1;
        #1;
        vectors++;
        if ({gpr_rd_addr0, gpr_rd_addr1} !== {5'd1, 5'd2}) begin
            miscompares++;
            $display("FAIL rd_addr got %0d,%0d required 1,2", gpr_rd_addr0, gpr_rd_addr1);
        end
        tick();
        vectors++;
        if ({id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_pc} !== {1'b1, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 32'h40}) begin
            miscompares++;
            $display("FAIL addu en=%b op=%0d in0=%0h in1=%0h dst=%0d we=%b pc=%0h required 1,0,5,7,3,1,40",
                     id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_pc);
        end
        ex_fwd_we = 1; ex_fwd_addr = 1; ex_fwd_data = 32'h10;
        mem_fwd_we = 1; mem_fwd_addr = 1; mem_fwd_data = 32'h20;
        tick();
        vectors++;
        if (id_alu_in0 !== 32'h10) begin
            miscompares++;
            $display("FAIL fwd_ex_prio in0 got %0h required 10", id_alu_in0);
        end
        ex_fwd_we = 0;
        tick();
        vectors++;
        if (id_alu_in0 !== 32'h20) begin
            miscompares++;
            $display("FAIL fwd_mem in0 got %0h required 20", id_alu_in0);
        end
        mem_fwd_we = 0;
        if_insn = r_i(6'h21, 0, 2, 0, 0);
        tick();
        vectors++;
        if ({id_en, id_alu_in0, id_gpr_we} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL r0 en=%b in0=%0h we=%b required 1,0,0", id_en, id_alu_in0, id_gpr_we);
        end
    endtask

    task automatic test_load_use();
        clr_in();
        rf[1] = 5; rf[2] = 7;
        ex_is_load = 1; ex_fwd_we = 1; ex_fwd_addr = 2; ex_fwd_data = 32'h99;
        if_insn = r_i(6'h21, 1, 2, 3, 0); if_en = 1;
        #1;
        vectors++;
        if ({ld_hazard, br_taken} !== 2'b10) begin
            miscompares++;
            $display("FAIL ld_use comb ld_hazard/br_taken got %b required 10", {ld_hazard, br_taken});
        end
        tick();
        vectors++;
        if (id_en !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_use bubble id_en got %b required 0", id_en);
        end
        if_insn = i_i(6'h04, 2, 2, 16'h3);
        #1;
        vectors++;
        if ({ld_hazard, br_taken} !== 2'b10) begin
            miscompares++;
            $display("FAIL ld_use beq ld_hazard/br_taken got %b required 10", {ld_hazard, br_taken});
        end
        if_insn = i_i(6'h0f, 2, 2, 16'h1234);
        #1;
        vectors++;
        if (ld_hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_use lui ld_hazard got %b required 0", ld_hazard);
        end
    endtask

    task automatic test_branch();
        clr_in();
        rf[1] = 9; rf[2] = 9;
        if_pc = 32'h100; if_en = 1; if_insn = i_i(6'h04, 1, 2, 16'h3);
        #1;
        vectors++;
        if ({br_taken, br_addr} !== {1'b1, 32'h110}) begin
            miscompares++;
            $display("FAIL beq_eq taken=%b addr=%0h required 1,110", br_taken, br_addr);
        end
        rf[2] = 8;
        #1;
        vectors++;
        if ({br_taken, br_addr} !== {1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL beq_ne taken=%b addr=%0h required 0,0", br_taken, br_addr);
        end
        if_insn = i_i(6'h05, 1, 2, 16'hfffe);
        #1;
        vectors++;
        if ({br_taken, br_addr} !== {1'b1, 32'hfc}) begin
            miscompares++;
            $display("FAIL bne_back taken=%b addr=%0h required 1,fc", br_taken, br_addr);
        end
        if_insn = r_i(6'h08, 1, 0, 0, 0);
        #1;
        vectors++;
        if ({br_taken, br_addr} !== {1'b1, 32'h9}) begin
            miscompares++;
            $display("FAIL jr taken=%b addr=%0h required 1,9", br_taken, br_addr);
        end
        stall = 1;
        #1;
        vectors++;
        if (br_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL jr_stall taken=%b required 0", br_taken);
        end
        stall = 0;
        if_insn = {6'h03, 26'h40};
        #1;
        vectors++;
        if ({br_taken, br_addr} !== {1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL jal taken=%b addr=%0h required 1,100", br_taken, br_addr);
        end
        tick();
        vectors++;
        if ({id_dst_addr, id_alu_in0, id_alu_in1, id_alu_op, id_gpr_we} !== {5'd31, 32'h108, 32'h108, 4'd9, 1'b1}) begin
            miscompares++;
            $display("FAIL jal_reg dst=%0d in0=%0h in1=%0h op=%0d we=%b required 31,108,108,9,1",
                     id_dst_addr, id_alu_in0, id_alu_in1, id_alu_op, id_gpr_we);
        end
    endtask

    task automatic test_stall_flush();
        clr_in();
        rf[1] = 5; rf[2] = 7;
        if_en = 1; if_pc = 32'h200; if_insn = r_i(6'h21, 1, 2, 3, 0);
        tick();
        stall = 1; if_pc = 32'h204; if_insn = i_i(6'h0d, 1, 4, 16'h00ff);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({id_en, id_pc, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we} !== {1'b1, 32'h200, 4'd0, 32'd5, 32'd7, 5'd3, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold cyc %0d en=%b pc=%0h op=%0d in0=%0h in1=%0h dst=%0d we=%b", i,
                         id_en, id_pc, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we);
            end
        end
        flush = 1;
        tick();
        vectors++;
        if ({id_en, id_gpr_we, id_mem_op, id_illegal} !== 5'b0) begin
            miscompares++;
            $display("FAIL flush_over_stall en/we/mem/ill got %b required 0", {id_en, id_gpr_we, id_mem_op, id_illegal});
        end
        flush = 0; stall = 0; if_insn = i_i(6'h08, 1, 4, 16'h1);
        tick();
        vectors++;
        if ({id_en, id_illegal, id_gpr_we, id_mem_op} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL illegal en/ill/we/mem got %b required 1100", {id_en, id_illegal, id_gpr_we, id_mem_op});
        end
        stall = 1; rst = 1;
        tick();
        vectors++;
        if ({id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_mem_op, id_mem_wr_data, id_illegal, id_pc} !== '0) begin
            miscompares++;
            $display("FAIL rst_in_stall id_* got %h required 0", {id_en, id_alu_op, id_alu_in0, id_alu_in1, id_dst_addr, id_gpr_we, id_mem_op, id_mem_wr_data, id_illegal, id_pc});
        end
        rst = 0; stall = 0; if_en = 0;
        tick();
        vectors++;
        if (id_en !== 1'b0) begin
            miscompares++;
            $display("FAIL if_en_low bubble id_en got %b required 0", id_en);
        end
    endtask

    function automatic logic [4:0] rr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rv();
        return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    endfunction

    function automatic logic [31:0] gen();
        logic [5:0] fns [10] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h00, 6'h02, 6'h08, 6'h20};
        logic [5:0] ops [12] = '{6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h20};
        int k = $urandom_range(0, 21);
        if (k < 10) return r_i(fns[k], rr(), rr(), rr(), 5'($urandom));
        return i_i(ops[k-10], rr(), rr(), 16'($urandom));
    endfunction

    task automatic test_random();
        st_t s;
        logic hz, bt;
        logic [31:0] ba;
        clr_in();
        rst = 1;
        tick();
        exp_q = '{default: '0};
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 99) == 0;
            if_en = $urandom_range(0, 9) != 0;
            stall = $urandom_range(0, 6) == 0;
            flush = $urandom_range(0, 9) == 0;
            ex_fwd_we = 1'($urandom); ex_fwd_addr = rr(); ex_fwd_data = rv(); ex_is_load = $urandom_range(0, 4) == 0;
            mem_fwd_we = 1'($urandom); mem_fwd_addr = rr(); mem_fwd_data = rv();
            rf[$urandom_range(0, 31)] = rv();
            if_pc = $urandom & 32'hffff_fffc;
            if_insn = gen();
            #1;
            model(if_pc, if_insn, s, hz, bt, ba);
            vectors++;
            if ({ld_hazard, br_taken, br_addr, gpr_rd_addr0, gpr_rd_addr1} !== {hz, bt, ba, if_insn[25:21], if_insn[20:16]}) begin
                miscompares++;
                $display("FAIL rnd_comb insn=%h hz=%b bt=%b ba=%h required %b %b %h", if_insn, ld_hazard, br_taken, br_addr, hz, bt, ba);
            end
            if (rst) exp_q = '{default: '0};
            else if (flush || (!stall && (hz || !if_en))) begin
                exp_q.en = 0; exp_q.we = 0; exp_q.mem = 0; exp_q.ill = 0;
            end else if (!stall) exp_q = s;
            tick();
            vectors++;
            if ({id_en, id_gpr_we, id_mem_op, id_illegal} !== {exp_q.en, exp_q.we, exp_q.mem, exp_q.ill}) begin
                miscompares++;
                $display("FAIL rnd_ctrl en/we/mem/ill got %b required %b", {id_en, id_gpr_we, id_mem_op, id_illegal},
                         {exp_q.en, exp_q.we, exp_q.mem, exp_q.ill});
            end
            if (exp_q.en) begin
                vectors++;
                if (id_pc !== exp_q.pc || (exp_q.we && id_dst_addr !== exp_q.dst)) begin
                    miscompares++;
                    $display("FAIL rnd_pc_dst pc=%h dst=%0d required %h %0d", id_pc, id_dst_addr, exp_q.pc, exp_q.dst);
                end
                if (!exp_q.dc) begin
                    vectors++;
                    if ({id_alu_op, id_alu_in0, id_alu_in1} !== {exp_q.op, exp_q.in0, exp_q.in1}) begin
                        miscompares++;
                        $display("FAIL rnd_alu op=%0d in0=%h in1=%h required %0d %h %h", id_alu_op, id_alu_in0, id_alu_in1,
                                 exp_q.op, exp_q.in0, exp_q.in1);
                    end
                end
                if (exp_q.mem == 2) begin
                    vectors++;
                    if (id_mem_wr_data !== exp_q.wd) begin
                        miscompares++;
                        $display("FAIL rnd_swdata got %h required %h", id_mem_wr_data, exp_q.wd);
                    end
                end
            end
        end
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        clr_in();
        test_reset();
        test_addu();
        test_load_use();
        test_branch();
        test_stall_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
